issue_queue_age: RTL
====================

// Module: issue_queue_age
// PURPOSE
//  Parametrised, out-of-order issue queue for one functional-unit cluster (ALU/MEM/BRU/MUL). It sits
//  between rename/dispatch and the FU pipes. It holds iq_entry_t records and tracks per-source
//  readiness using physical-register wake broadcasts. Each cycle it selects up to ISSUE_NUM ready
//  entries, oldest first, using an age matrix, and drives registered issued_instr_t to the FUs.
// PARAMETERS
//  DEPTH      16  number of entries (power of two not required, >= WRITE_NUM)
//  WRITE_NUM  2   dispatch write ports per cycle
//  ISSUE_NUM  2   issue ports per cycle (port 0 gets oldest ready)
//  WAKE_NUM   12  wake broadcast ports (issue_pkg::WAKE_NUM for ALU cluster: ALU_WAKE_NUM)
// PORTS
//  clk        in   1                        clock
//  resetn     in   1                        async active-low reset
//  flush      in   1                        pipeline flush (mispredict/exception)
//  write      in   WRITE_NUM x write_req_t  dispatch requests, slot 0 older than slot 1
//  wr_ready   out  1                        queue can accept WRITE_NUM entries this cycle
//  wake       in   WAKE_NUM x wake_req_t    preg ready broadcasts
//  fu_ready   in   ISSUE_NUM                FU k can accept an instruction next cycle
//  issue      out  ISSUE_NUM x issued_instr_t  registered issue bundle
//  count      out  $clog2(DEPTH+1)          occupied entries
// BEHAVIOUR
//  Clock is clk. Reset is resetn: asynchronous, active-low.
//  Reset: all entries invalid, age matrix 0, issue[*].valid=0, count=0, wr_ready=1.
//  Admission:
//   - wr_ready = (DEPTH - count) >= WRITE_NUM. It is combinational from registered count only.
//   - Same-cycle frees are not credited (conservative).
//   - Writes with valid=1 while wr_ready=0 are dropped; dispatch must not do this (assertion).
//   - Each valid write takes the lowest-index free slot, in slot order.
//   - The age row is set so the new entry is younger than all resident entries and younger than
//     lower-numbered same-cycle writes.
//  Source readiness:
//   - At write, src ready = !src.valid | src.forward_en | any wake[j].valid & wake[j].id==src.pid.
//   - A stored entry sets src ready on a matching valid wake. The ready bit is sticky until the
//     entry frees.
//   - Entry is eligible when valid & src1 ready & src2 ready.
//  Timing:
//   - Entry written at edge E is selectable in the cycle after E.
//   - issue valid appears after the next edge, so min write->issue is 2 edges.
//   - A wake in cycle c makes the entry selectable in cycle c+1.
//  Select:
//   - Among eligible entries, port k takes the k-th oldest (age matrix, no index priority).
//   - Only ports with fu_ready[k]=1 consume an entry. Ports are filled lowest k first among ready
//     ports, so the oldest goes to the lowest ready port.
//   - A port with fu_ready=0 gets valid=0 next cycle.
//   - Selected entries free at the same edge their issue register loads. Their age column is
//     cleared.
//  issue fields:
//   - imm, ctl, pc, src1/src2 = src.id, psrc = src.pid, forward_en copied from src,
//     dst = entry.dst (zero-extended/truncated to preg_addr_t width per package).
//   - valid=1 only for a consumed select.
//  count(next) = count + #accepted writes - #issued. There are no wrap or overflow cases because
//  admission is gated.
//  Flush:
//   - At the flush edge all entries are invalidated, count=0, and all issue valid=0.
//   - Writes and wakes in the flush cycle are discarded.
//   - wr_ready follows the new count next cycle.
//  Simultaneous events:
//   - An entry selected and woken in the same cycle: selection wins.
//   - A slot freed and needed by a write in the same cycle is not reused until the next cycle.
//  Async reset mid-operation: state clears immediately; no partial issue.
// STRUCTURE
//  issue_pkg gains:
//   - iq_age_row_t (logic [DEPTH-1:0])
//   - an issue-queue config struct/params
//   - helper function src_ready_at_write()
//  Reuse iq_entry_t, write_req_t, wake_req_t and issued_instr_t unchanged.
//  Sub-module iq_age_select (DEPTH, ISSUE_NUM): eligible vector + age matrix + fu_ready ->
//  one-hot grants per port. It is combinational and tested standalone.
//  Top holds the entry array, ready bits, allocator, age matrix update and issue registers.
// TESTING
//  1 Reset, write 1 entry (both srcs forward_en=1), fu_ready=1:
//    -> issue[0].valid=1 two edges later, count returns 0.
//  2 Write A (psrc1=5, not ready) then B (ready). Wake id=5 three cycles later:
//    -> B issues first, A issues on port 0 two edges after the wake.
//  3 Fill to DEPTH-1 with WRITE_NUM=2:
//    -> wr_ready=0. Issue one entry -> wr_ready=1 the cycle after count drops.
//  4 Four eligible entries, ages a<b<c<d, fu_ready=2'b10:
//    -> only port1 valid, carrying a. Next cycle fu_ready=2'b11 -> b on port0, c on port1.
//  5 Wake for pid 9 in the same cycle a write with psrc2=9 arrives:
//    -> entry eligible the next cycle and issues without a further wake.
//  6 Full queue with pending wakes, assert flush:
//    -> count=0, all issue valid=0, wr_ready=1 next cycle.
//    Repeat with resetn pulsed low mid-cycle -> same state immediately.

Source files
------------

// File: rtl/issue_queue_age_pkg.sv
// rtl/issue_queue_age_pkg.sv - types, parameters and helpers for the age-ordered issue queue
package issue_queue_age_pkg;

  localparam int IQ_DEPTH     = 16;
  localparam int IQ_WRITE_NUM = 2;
  localparam int IQ_ISSUE_NUM = 2;
  localparam int ALU_WAKE_NUM = 12;
  localparam int PREG_W       = 7;
  localparam int AREG_W       = 5;

  typedef struct packed {
    int depth;
    int write_num;
    int issue_num;
    int wake_num;
  } iq_cfg_t;

  localparam iq_cfg_t IQ_CFG = '{
    depth:     IQ_DEPTH,
    write_num: IQ_WRITE_NUM,
    issue_num: IQ_ISSUE_NUM,
    wake_num:  ALU_WAKE_NUM
  };

  typedef logic [PREG_W-1:0]   preg_addr_t;
  typedef logic [AREG_W-1:0]   areg_addr_t;
  typedef logic [IQ_DEPTH-1:0] iq_age_row_t;

  typedef struct packed {
    logic       valid;
    areg_addr_t id;
    preg_addr_t pid;
    logic       forward_en;
  } src_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [7:0]  ctl;
    src_t        src1;
    src_t        src2;
    preg_addr_t  dst;
  } iq_entry_t;

  typedef struct packed {
    logic      valid;
    iq_entry_t entry;
  } write_req_t;

  typedef struct packed {
    logic       valid;
    preg_addr_t id;
  } wake_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [7:0]  ctl;
    areg_addr_t  src1;
    areg_addr_t  src2;
    preg_addr_t  psrc1;
    preg_addr_t  psrc2;
    logic        forward_en1;
    logic        forward_en2;
    preg_addr_t  dst;
  } issued_instr_t;

  // A source is usable at dispatch if unused, forwarded, or woken in the same cycle
  function automatic logic src_ready_at_write(input src_t s, input logic wake_hit);
    return !s.valid | s.forward_en | wake_hit;
  endfunction

  function automatic issued_instr_t to_issued(input iq_entry_t e);
    issued_instr_t r;
    r.valid       = 1'b1;
    r.pc          = e.pc;
    r.imm         = e.imm;
    r.ctl         = e.ctl;
    r.src1        = e.src1.id;
    r.src2        = e.src2.id;
    r.psrc1       = e.src1.pid;
    r.psrc2       = e.src2.pid;
    r.forward_en1 = e.src1.forward_en;
    r.forward_en2 = e.src2.forward_en;
    r.dst         = e.dst;
    return r;
  endfunction

endpackage

// File: rtl/issue_queue_age_select.sv
// rtl/issue_queue_age_select.sv - oldest-first grant per ready port from an age matrix
module iq_age_select #(
  parameter int DEPTH     = 16,
  parameter int ISSUE_NUM = 2
) (
  input  logic [DEPTH-1:0]     eligible,
  input  logic [DEPTH-1:0]     older    [DEPTH],
  input  logic [ISSUE_NUM-1:0] fu_ready,
  output logic [DEPTH-1:0]     grant    [ISSUE_NUM]
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] rank [DEPTH];
  logic [CW-1:0] slot;

  // rank = number of eligible entries older than this one (0 = oldest)
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rank[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        rank[i] = rank[i] + CW'(eligible[j] & older[i][j]);
      end
    end
  end

  // ready ports take successive ranks, lowest port first; stalled ports skip
  always_comb begin
    slot = '0;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      grant[k] = '0;
      if (fu_ready[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          grant[k][i] = eligible[i] && (rank[i] == slot);
        end
        slot = slot + CW'(1);
      end
    end
  end

endmodule

// File: rtl/issue_queue_age.sv
// rtl/issue_queue_age.sv - out-of-order issue queue with wake tracking and age-ordered select
module issue_queue_age
  import issue_queue_age_pkg::*;
#(
  parameter int DEPTH     = IQ_CFG.depth,
  parameter int WRITE_NUM = IQ_CFG.write_num,
  parameter int ISSUE_NUM = IQ_CFG.issue_num,
  parameter int WAKE_NUM  = IQ_CFG.wake_num
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  write_req_t                 write    [WRITE_NUM],
  output logic                       wr_ready,
  input  wake_req_t                  wake     [WAKE_NUM],
  input  logic [ISSUE_NUM-1:0]       fu_ready,
  output issued_instr_t              issue    [ISSUE_NUM],
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  iq_entry_t            ent      [DEPTH];
  logic [DEPTH-1:0]     vld, rdy1, rdy2, eligible, freed, taken;
  logic [DEPTH-1:0]     hit1, hit2;
  logic [DEPTH-1:0]     older    [DEPTH];
  logic [DEPTH-1:0]     alloc_oh [WRITE_NUM];
  logic [DEPTH-1:0]     prior_oh [WRITE_NUM];
  logic [DEPTH-1:0]     grant    [ISSUE_NUM];
  logic [WRITE_NUM-1:0] whit1, whit2, accept, wr_valid;
  logic [ISSUE_NUM-1:0] port_fire;
  iq_entry_t            sel_ent  [ISSUE_NUM];
  logic [CW-1:0]        n_accept, n_issue;

  // Room is judged on the registered count only; same-cycle frees are not credited
  assign wr_ready = (DEPTH - int'(count)) >= WRITE_NUM;
  assign eligible = vld & rdy1 & rdy2;

  iq_age_select #(.DEPTH(DEPTH), .ISSUE_NUM(ISSUE_NUM)) u_select (
    .eligible (eligible),
    .older    (older),
    .fu_ready (fu_ready),
    .grant    (grant)
  );

  // wake matching against resident sources and incoming write sources
  always_comb begin
    hit1  = '0;
    hit2  = '0;
    whit1 = '0;
    whit2 = '0;
    for (int j = 0; j < WAKE_NUM; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        hit1[i] = hit1[i] | (wake[j].valid && (wake[j].id == ent[i].src1.pid));
        hit2[i] = hit2[i] | (wake[j].valid && (wake[j].id == ent[i].src2.pid));
      end
      for (int w = 0; w < WRITE_NUM; w++) begin
        whit1[w] = whit1[w] | (wake[j].valid && (wake[j].id == write[w].entry.src1.pid));
        whit2[w] = whit2[w] | (wake[j].valid && (wake[j].id == write[w].entry.src2.pid));
      end
    end
  end

  // per-port selected entry, freed mask and issue count
  always_comb begin
    freed   = '0;
    n_issue = '0;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      port_fire[k] = |grant[k];
      sel_ent[k]   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (grant[k][i]) sel_ent[k] = ent[i];
      end
      freed   = freed | grant[k];
      n_issue = n_issue + CW'(port_fire[k]);
    end
  end

  // lowest free slot per write in slot order; slots freed this cycle are not reused
  always_comb begin
    taken    = '0;
    n_accept = '0;
    for (int w = 0; w < WRITE_NUM; w++) begin
      wr_valid[w] = write[w].valid;
      prior_oh[w] = taken;
      alloc_oh[w] = '0;
      accept[w]   = 1'b0;
      if (write[w].valid && wr_ready && !flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!vld[i] && !taken[i] && !accept[w]) begin
            alloc_oh[w][i] = 1'b1;
            accept[w]      = 1'b1;
          end
        end
      end
      taken    = taken | alloc_oh[w];
      n_accept = n_accept + CW'(accept[w]);
    end
  end

  // entry payload; only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    for (int w = 0; w < WRITE_NUM; w++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[w][i]) ent[i] <= write[w].entry;
      end
    end
  end

  // valid/ready bits, age matrix (older[i][j]: j is older than i) and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld   <= '0;
      rdy1  <= '0;
      rdy2  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (flush) begin
      vld   <= '0;
      rdy1  <= '0;
      rdy2  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (freed[i]) vld[i] <= 1'b0;
        if (hit1[i])  rdy1[i] <= 1'b1;
        if (hit2[i])  rdy2[i] <= 1'b1;
        older[i] <= older[i] & ~freed;
      end
      for (int w = 0; w < WRITE_NUM; w++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (alloc_oh[w][i]) begin
            vld[i]   <= 1'b1;
            rdy1[i]  <= src_ready_at_write(write[w].entry.src1, whit1[w]);
            rdy2[i]  <= src_ready_at_write(write[w].entry.src2, whit2[w]);
            older[i] <= (vld & ~freed) | prior_oh[w];
          end
        end
      end
      count <= count + n_accept - n_issue;
    end
  end

  // registered issue bundle; a port carries data only for a consumed select
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < ISSUE_NUM; k++) issue[k] <= '0;
    end else begin
      for (int k = 0; k < ISSUE_NUM; k++) begin
        if (!flush && port_fire[k]) issue[k] <= to_issued(sel_ent[k]);
        else                        issue[k] <= '0;
      end
    end
  end

  a_no_write_when_full: assert property (@(posedge clk) disable iff (!resetn)
    !((|wr_valid) && !wr_ready));

endmodule
